// File: rtl/a7_ddr3_pkg.sv
// Shared definitions for the DDR3 read/write burst arbiter: state encoding,
// command opcodes and address width.
package a7_ddr3_pkg;

   localparam int unsigned ADDR_W = 28;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StArb  = 2'd1,
      StWr   = 2'd2,
      StRd   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/a7_ddr3_addr_ptr.sv
// Burst start-address pointer: advances by STEP on adv, returns to 0 after ADDR_END.
module a7_ddr3_addr_ptr
   import a7_ddr3_pkg::*;
#(
   parameter logic [ADDR_W-1:0] STEP     = 28'd512,
   parameter logic [ADDR_W-1:0] ADDR_END = 28'h3FF_FFF8
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              adv,
   output logic [ADDR_W-1:0] ptr
);

   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (adv) begin
         ptr_d = (ptr_q == ADDR_END) ? '0 : ptr_q + STEP;
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/a7_ddr3_arbit.sv
// Round-robin arbiter issuing DDR3 write/read burst commands after calibration.
// Define A7_DDR3_ARB_WDOG_EN to build in the burst watchdog and timeout_err output.
module a7_ddr3_arbit
   import a7_ddr3_pkg::*;
#(
   parameter int unsigned       BURST_LEN   = 64,
   parameter logic [ADDR_W-1:0] ADDR_END    = 28'h3FF_FFF8,
   parameter int unsigned       TIMEOUT_CYC = 4095
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              calib_done,
   input  logic              wr_req,
   input  logic              rd_req,
   output logic              wr_cmd_start,
   output logic [2:0]        wr_cmd_instr,
   output logic [6:0]        wr_cmd_bl,
   output logic [ADDR_W-1:0] wr_cmd_addr,
   input  logic              wr_end,
   output logic              rd_cmd_start,
   output logic [2:0]        rd_cmd_instr,
   output logic [6:0]        rd_cmd_bl,
   output logic [ADDR_W-1:0] rd_cmd_addr,
   input  logic              rd_end,
`ifdef A7_DDR3_ARB_WDOG_EN
   output logic              timeout_err,
`endif
   output logic              arb_busy
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN * 8);
   localparam logic [6:0]        BL   = 7'(BURST_LEN);

   if (BURST_LEN < 1 || BURST_LEN > 127 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("a7_ddr3_arbit: BURST_LEN must be 1..127 and TIMEOUT_CYC at least 1");
   end

   arb_state_e        state_q;
   logic              last_grant_wr_q;
   logic              grant_wr;
   logic              grant_rd;
   logic              wr_adv;
   logic              rd_adv;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;

`ifdef A7_DDR3_ARB_WDOG_EN
   localparam int unsigned WDOG_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
   logic [WDOG_W-1:0] wdog_q;
`endif

   // On a tie the side that did not win last time gets the grant.
   assign grant_wr = wr_req & (~rd_req | ~last_grant_wr_q);
   assign grant_rd = rd_req & (~wr_req | last_grant_wr_q);

   assign wr_adv = (state_q == StWr) & wr_end;
   assign rd_adv = (state_q == StRd) & rd_end;

   assign wr_cmd_instr = CMD_WR;
   assign rd_cmd_instr = CMD_RD;

   a7_ddr3_addr_ptr #(
      .STEP     (STEP),
      .ADDR_END (ADDR_END)
   ) u_wr_ptr (
      .sclk (sclk),
      .rst  (rst),
      .adv  (wr_adv),
      .ptr  (wr_ptr)
   );

   a7_ddr3_addr_ptr #(
      .STEP     (STEP),
      .ADDR_END (ADDR_END)
   ) u_rd_ptr (
      .sclk (sclk),
      .rst  (rst),
      .adv  (rd_adv),
      .ptr  (rd_ptr)
   );

   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q         <= StIdle;
         last_grant_wr_q <= 1'b0;
         wr_cmd_start    <= 1'b0;
         rd_cmd_start    <= 1'b0;
         wr_cmd_addr     <= '0;
         rd_cmd_addr     <= '0;
         wr_cmd_bl       <= BL;
         rd_cmd_bl       <= BL;
         arb_busy        <= 1'b0;
`ifdef A7_DDR3_ARB_WDOG_EN
         timeout_err     <= 1'b0;
         wdog_q          <= '0;
`endif
      end else begin
         wr_cmd_start <= 1'b0;
         rd_cmd_start <= 1'b0;
`ifdef A7_DDR3_ARB_WDOG_EN
         timeout_err  <= 1'b0;
`endif
         case (state_q)
            StIdle: begin
               if (calib_done) begin
                  state_q <= StArb;
               end
            end
            StArb: begin
               if (!calib_done) begin
                  state_q <= StIdle;
               end else if (grant_wr) begin
                  state_q      <= StWr;
                  wr_cmd_start <= 1'b1;
                  wr_cmd_addr  <= wr_ptr;
                  wr_cmd_bl    <= BL;
                  arb_busy     <= 1'b1;
`ifdef A7_DDR3_ARB_WDOG_EN
                  wdog_q       <= '0;
`endif
               end else if (grant_rd) begin
                  state_q      <= StRd;
                  rd_cmd_start <= 1'b1;
                  rd_cmd_addr  <= rd_ptr;
                  rd_cmd_bl    <= BL;
                  arb_busy     <= 1'b1;
`ifdef A7_DDR3_ARB_WDOG_EN
                  wdog_q       <= '0;
`endif
               end
            end
            StWr: begin
               // Losing calibration mid-burst lets the burst complete first.
               if (wr_end) begin
                  state_q         <= calib_done ? StArb : StIdle;
                  last_grant_wr_q <= 1'b1;
                  arb_busy        <= 1'b0;
`ifdef A7_DDR3_ARB_WDOG_EN
               end else if (wdog_q == WDOG_LAST) begin
                  state_q         <= calib_done ? StArb : StIdle;
                  last_grant_wr_q <= 1'b1;
                  arb_busy        <= 1'b0;
                  timeout_err     <= 1'b1;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
`endif
               end
            end
            StRd: begin
               if (rd_end) begin
                  state_q         <= calib_done ? StArb : StIdle;
                  last_grant_wr_q <= 1'b0;
                  arb_busy        <= 1'b0;
`ifdef A7_DDR3_ARB_WDOG_EN
               end else if (wdog_q == WDOG_LAST) begin
                  state_q         <= calib_done ? StArb : StIdle;
                  last_grant_wr_q <= 1'b0;
                  arb_busy        <= 1'b0;
                  timeout_err     <= 1'b1;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
`endif
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_a7_ddr3_arbit.sv
// Directed self-checking bench for a7_ddr3_arbit (ADDR_END=0x600, TIMEOUT_CYC=50).
module tb_a7_ddr3_arbit;

   logic        sclk = 1'b0;
   logic        rst = 1'b1;
   logic        calib_done = 1'b0;
   logic        wr_req = 1'b0;
   logic        rd_req = 1'b0;
   logic        wr_end = 1'b0;
   logic        rd_end = 1'b0;
   logic        wr_cmd_start;
   logic        rd_cmd_start;
   logic [2:0]  wr_cmd_instr;
   logic [2:0]  rd_cmd_instr;
   logic [6:0]  wr_cmd_bl;
   logic [6:0]  rd_cmd_bl;
   logic [27:0] wr_cmd_addr;
   logic [27:0] rd_cmd_addr;
   logic        arb_busy;
`ifdef A7_DDR3_ARB_WDOG_EN
   logic        timeout_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 sclk = ~sclk;

   a7_ddr3_arbit #(
      .BURST_LEN   (64),
      .ADDR_END    (28'h600),
      .TIMEOUT_CYC (50)
   ) dut (
      .sclk         (sclk),
      .rst          (rst),
      .calib_done   (calib_done),
      .wr_req       (wr_req),
      .rd_req       (rd_req),
      .wr_cmd_start (wr_cmd_start),
      .wr_cmd_instr (wr_cmd_instr),
      .wr_cmd_bl    (wr_cmd_bl),
      .wr_cmd_addr  (wr_cmd_addr),
      .wr_end       (wr_end),
      .rd_cmd_start (rd_cmd_start),
      .rd_cmd_instr (rd_cmd_instr),
      .rd_cmd_bl    (rd_cmd_bl),
      .rd_cmd_addr  (rd_cmd_addr),
      .rd_end       (rd_end),
`ifdef A7_DDR3_ARB_WDOG_EN
      .timeout_err  (timeout_err),
`endif
      .arb_busy     (arb_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Waits for either start pulse; got stays 0 if the budget runs out.
   task automatic wait_start(input int budget, output bit got, output bit is_wr,
                             output logic [27:0] addr);
      got   = 1'b0;
      is_wr = 1'b0;
      addr  = '0;
      for (int i = 0; i < budget && !got; i++) begin
         step();
         if (wr_cmd_start || rd_cmd_start) begin
            got   = 1'b1;
            is_wr = wr_cmd_start;
            addr  = wr_cmd_start ? wr_cmd_addr : rd_cmd_addr;
         end
      end
   endtask

   task automatic end_burst(input bit is_wr, input int hold);
      repeat (hold) step();
      if (is_wr) wr_end = 1'b1;
      else       rd_end = 1'b1;
      step();
      wr_end = 1'b0;
      rd_end = 1'b0;
   endtask

   task automatic expect_start(input string tag, input bit exp_wr, input logic [27:0] exp_addr);
      bit          got;
      bit          is_wr;
      logic [27:0] addr;
      wait_start(20, got, is_wr, addr);
      check({tag, "_seen"}, 32'(got), 32'd1);
      check({tag, "_dir"},  32'(is_wr), 32'(exp_wr));
      check({tag, "_addr"}, 32'(addr), 32'(exp_addr));
   endtask

   initial begin
      int          starts;
      logic [27:0] wr_seq [5];
      logic [27:0] tie_addr [5];

      // Reset state and no activity before calibration.
      wr_req = 1'b1;
      do_reset();
      check("rst_busy",     32'(arb_busy), 32'd0);
      check("rst_wr_start", 32'(wr_cmd_start), 32'd0);
      check("rst_rd_start", 32'(rd_cmd_start), 32'd0);
      check("rst_wr_addr",  32'(wr_cmd_addr), 32'd0);
      check("rst_rd_addr",  32'(rd_cmd_addr), 32'd0);
      starts = 0;
      repeat (100) begin
         step();
         if (wr_cmd_start || rd_cmd_start || arb_busy) starts++;
      end
      check("precal_starts", 32'(starts), 32'd0);

      // Start pulse two cycles after calib_done rises.
      calib_done = 1'b1;
      step();
      check("cal_gap1_start", 32'(wr_cmd_start), 32'd0);
      step();
      check("cal_wr_start", 32'(wr_cmd_start), 32'd1);
      check("cal_wr_addr",  32'(wr_cmd_addr), 32'd0);
      check("cal_wr_bl",    32'(wr_cmd_bl), 32'd64);
      check("cal_wr_instr", 32'(wr_cmd_instr), 32'd0);
      check("cal_busy",     32'(arb_busy), 32'd1);
      check("rd_bl",        32'(rd_cmd_bl), 32'd64);
      check("rd_instr",     32'(rd_cmd_instr), 32'd1);
      step();
      check("cal_pulse_len", 32'(wr_cmd_start), 32'd0);
      repeat (3) step();
      check("cal_addr_hold", 32'(wr_cmd_addr), 32'd0);
      end_burst(1'b1, 0);
      check("end_gap_start", 32'(wr_cmd_start), 32'd0);
      check("end_gap_busy",  32'(arb_busy), 32'd0);
      step();
      check("end_next_start", 32'(wr_cmd_start), 32'd1);
      check("end_next_addr",  32'(wr_cmd_addr), 32'h200);
      wr_req = 1'b0;
      end_burst(1'b1, 2);

      // Round-robin on permanent tie; stray wr_end during a read is ignored.
      do_reset();
      wr_req = 1'b1;
      rd_req = 1'b1;
      tie_addr[0] = 28'h000;
      tie_addr[1] = 28'h000;
      tie_addr[2] = 28'h200;
      tie_addr[3] = 28'h200;
      tie_addr[4] = 28'h400;
      for (int k = 0; k < 5; k++) begin
         expect_start($sformatf("tie%0d", k), (k % 2) == 0, tie_addr[k]);
         if (k == 1) begin
            wr_end = 1'b1;
            step();
            wr_end = 1'b0;
            starts = 0;
            repeat (3) begin
               step();
               if (wr_cmd_start || rd_cmd_start || !arb_busy) starts++;
            end
            check("stray_wr_end", 32'(starts), 32'd0);
         end
         end_burst((k % 2) == 0, 2);
      end

      // Write pointer wrap at ADDR_END.
      wr_req = 1'b0;
      rd_req = 1'b0;
      do_reset();
      wr_req = 1'b1;
      wr_seq[0] = 28'h000;
      wr_seq[1] = 28'h200;
      wr_seq[2] = 28'h400;
      wr_seq[3] = 28'h600;
      wr_seq[4] = 28'h000;
      for (int k = 0; k < 5; k++) begin
         expect_start($sformatf("wrap%0d", k), 1'b1, wr_seq[k]);
         end_burst(1'b1, 2);
      end

      // Reset mid-read aborts; first tie afterwards goes to write at 0.
      wr_req = 1'b0;
      do_reset();
      rd_req = 1'b1;
      expect_start("rdabort", 1'b0, 28'h000);
      repeat (10) step();
      rst = 1'b1;
      step();
      check("abort_busy",  32'(arb_busy), 32'd0);
      check("abort_start", 32'(rd_cmd_start), 32'd0);
      rst = 1'b0;
      wr_req = 1'b1;
      expect_start("post_abort", 1'b1, 28'h000);

`ifdef A7_DDR3_ARB_WDOG_EN
      // Watchdog: no wr_end, timeout 50 cycles after start, address repeats.
      rd_req = 1'b0;
      do_reset();
      expect_start("wdog_first", 1'b1, 28'h000);
      starts = 0;
      for (int i = 1; i <= 70 && starts == 0; i++) begin
         step();
         if (timeout_err) starts = i;
      end
      check("wdog_cycle", 32'(starts), 32'd50);
      check("wdog_busy",  32'(arb_busy), 32'd0);
      expect_start("wdog_retry", 1'b1, 28'h000);
`else
      // Without the watchdog an unfinished burst is held indefinitely.
      rd_req = 1'b0;
      do_reset();
      expect_start("hold_first", 1'b1, 28'h000);
      repeat (100) step();
      check("hold_busy",  32'(arb_busy), 32'd1);
      check("hold_start", 32'(wr_cmd_start), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
